// File: rtl/hadamard8_ctrl_if.sv
// Stream and datapath signal bundle for the 8-point Hadamard frame sequencer.
// slave: the sequencer's view. master: the sample source, consumer and datapath side.
interface hadamard8_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_last;
  logic        hd_start;
  logic [63:0] hd_x;
  logic [79:0] hd_y;

  modport slave (
    input  in_valid, in_data, out_ready, hd_y,
    output in_ready, out_valid, out_data, out_last, hd_start, hd_x
  );

  modport master (
    output in_valid, in_data, out_ready, hd_y,
    input  in_ready, out_valid, out_data, out_last, hd_start, hd_x
  );
endinterface

// File: rtl/hadamard8_ctrl.sv
// Frame sequencer for the 8-point Hadamard datapath: packs 8 serial samples, runs the
// datapath for PIPE_DEPTH cycles, captures and drains 8 results. Option: HADAMARD8_CTRL_SCALE_EN.
module hadamard8_ctrl #(
  parameter int PIPE_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  hadamard8_ctrl_if.slave  bus,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, RUN, CAPT, DRAIN} state_t;

  state_t      state_reg;
  logic [2:0]  lidx_reg;
  logic [2:0]  oidx_reg;
  logic [1:0]  run_cnt_reg;
  logic [7:0]  x_buf [8];
  logic [9:0]  y_buf [8];

  logic        in_ready_reg;
  logic        hd_start_reg;
  logic        out_valid_reg;
  logic        out_last_reg;
  logic [9:0]  out_data_reg;

  function automatic logic [9:0] scale_result(input logic [9:0] y);
`ifdef HADAMARD8_CTRL_SCALE_EN
    return {{3{y[9]}}, y[9:3]};
`else
    return y;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LOAD;
      lidx_reg      <= '0;
      oidx_reg      <= '0;
      run_cnt_reg   <= '0;
      in_ready_reg  <= 1'b0;
      hd_start_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      for (int i = 0; i < 8; i++) begin
        x_buf[i] <= '0;
        y_buf[i] <= '0;
      end
    end else begin
      case (state_reg)
        LOAD: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            x_buf[lidx_reg] <= bus.in_data;
            lidx_reg        <= lidx_reg + 3'd1;
            if (lidx_reg == 3'd7) begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b0;
              hd_start_reg <= 1'b1;
              run_cnt_reg  <= '0;
            end
          end
        end
        RUN: begin
          // hd_start already rose on entry, so the last enabled cycle is count PIPE_DEPTH-1
          run_cnt_reg <= run_cnt_reg + 2'd1;
          if (run_cnt_reg == 2'(PIPE_DEPTH - 1)) begin
            state_reg    <= CAPT;
            hd_start_reg <= 1'b0;
          end
        end
        CAPT: begin
          for (int i = 0; i < 8; i++) begin
            y_buf[i] <= bus.hd_y[10*i +: 10];
          end
          out_data_reg  <= scale_result(bus.hd_y[9:0]);
          out_valid_reg <= 1'b1;
          out_last_reg  <= 1'b0;
          oidx_reg      <= '0;
          state_reg     <= DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (oidx_reg == 3'd7) begin
              state_reg     <= LOAD;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              in_ready_reg  <= 1'b1;
              oidx_reg      <= '0;
            end else begin
              oidx_reg     <= oidx_reg + 3'd1;
              out_data_reg <= scale_result(y_buf[oidx_reg + 3'd1]);
              out_last_reg <= (oidx_reg == 3'd6);
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pack_x
      assign bus.hd_x[8*gi +: 8] = x_buf[gi];
    end
  endgenerate

  assign bus.in_ready  = in_ready_reg;
  assign bus.hd_start  = hd_start_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_data  = out_data_reg;
  assign busy          = (state_reg != LOAD) || (lidx_reg != 3'd0);

endmodule

// File: tb/tb_hadamard8_ctrl.sv
// Randomised bench for hadamard8_ctrl with a butterfly datapath model and a
// sign-matrix reference scoreboard; honours HADAMARD8_CTRL_SCALE_EN.
module tb_hadamard8_ctrl;
  localparam int PIPE_DEPTH = 3;

  typedef int vec8_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;

  hadamard8_ctrl_if bus();

  hadamard8_ctrl #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Datapath model: three enabled stages of radix-2 butterflies, 10-bit results
  function automatic vec8_t bfly(input vec8_t a, input int s);
    vec8_t r;
    for (int i = 0; i < 8; i++) begin
      if ((i & s) == 0) begin
        r[i]     = a[i] + a[i+s];
        r[i+s]   = a[i] - a[i+s];
      end
    end
    return r;
  endfunction

  vec8_t xv, st1, st2, st3;

  always_comb begin
    for (int i = 0; i < 8; i++) xv[i] = int'($signed(bus.hd_x[8*i +: 8]));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1 <= '{default: 0};
      st2 <= '{default: 0};
      st3 <= '{default: 0};
    end else if (bus.hd_start) begin
      st1 <= bfly(xv, 1);
      st2 <= bfly(st1, 2);
      st3 <= bfly(st2, 4);
    end
  end

  always_comb begin
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[10*i +: 10] = 10'(st3[i]);
    bus.hd_y = v;
  end

  // Reference: y_k = sum_n (-1)^popcount(k&n) x_n, wrapped to 10 bits, optionally /8 floor
  function automatic int ref_y(input vec8_t s, input int k);
    int acc = 0;
    int m;
    for (int n = 0; n < 8; n++) begin
      if (($countones(k & n) % 2) == 1) acc -= s[n];
      else acc += s[n];
    end
    m = (acc + 512) % 1024;
    if (m < 0) m += 1024;
    acc = m - 512;
`ifdef HADAMARD8_CTRL_SCALE_EN
    if (acc >= 0) acc = acc / 8;
    else acc = -((-acc + 7) / 8);
`endif
    return acc;
  endfunction

  // Scoreboard / monitor, sampled on the falling edge
  vec8_t cur;
  int    cur_n = 0;
  int    exp_q[$];
  bit    last_q[$];
  int    beat_log[$];
  int    frames_done = 0;
  int    lat_cnt = 0;
  bit    lat_arm = 0;
  bit    prev_ov = 0;
  bit    hold_pend = 0;
  int    hold_val = 0;
  int    hs_run = 0;
  logic [63:0] run_x;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_n = 0;
      exp_q.delete();
      last_q.delete();
      lat_arm = 0;
      prev_ov = 0;
      hold_pend = 0;
      hs_run = 0;
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_last", int'(bus.out_last), 0);
      check("rst_hd_start", int'(bus.hd_start), 0);
      check("rst_hd_x_zero", int'(bus.hd_x != 64'd0), 0);
      check("rst_out_data", int'(bus.out_data), 0);
    end else begin
      if (hold_pend) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'($signed(bus.out_data)), hold_val);
        hold_pend = 0;
      end
      if (bus.out_valid && !bus.out_ready) begin
        hold_pend = 1;
        hold_val  = int'($signed(bus.out_data));
      end
      if (bus.hd_start) begin
        if (hs_run == 0) run_x = bus.hd_x;
        else check("hd_x_stable", int'(bus.hd_x == run_x), 1);
        hs_run++;
      end else if (hs_run != 0) begin
        check("hd_start_len", hs_run, PIPE_DEPTH);
        hs_run = 0;
      end
      if (lat_arm) begin
        lat_cnt++;
        if (bus.out_valid && !prev_ov) begin
          check("latency", lat_cnt, PIPE_DEPTH + 1);
          lat_arm = 0;
        end else if (lat_cnt > 20) begin
          check("latency_timeout", lat_cnt, PIPE_DEPTH + 1);
          lat_arm = 0;
        end
      end
      if (bus.out_valid) begin
        check("in_ready_in_drain", int'(bus.in_ready), 0);
        check("busy_in_drain", int'(busy), 1);
      end
      if (bus.in_valid && bus.in_ready) begin
        cur[cur_n] = int'($signed(bus.in_data));
        cur_n++;
        if (cur_n == 8) begin
          for (int k = 0; k < 8; k++) begin
            exp_q.push_back(ref_y(cur, k));
            last_q.push_back(k == 7);
          end
          cur_n   = 0;
          lat_arm = 1;
          lat_cnt = -1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        int got;
        got = int'($signed(bus.out_data));
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          int e;
          bit l;
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("out_data", got, e);
          check("out_last", int'(bus.out_last), int'(l));
          $display("beat data=%0d last=%0d expected=%0d", got, bus.out_last, e);
          if (l) frames_done++;
        end
        beat_log.push_back(got);
      end
      prev_ov = bus.out_valid;
    end
  end

  // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  int orm = 0;
  int or_phase = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (orm)
        1: begin
          bus.out_ready = ((or_phase % 4) == 0) || ((or_phase % 4) == 3);
          or_phase++;
        end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input vec8_t s, input int count, input bit gaps);
    @(posedge clk);
    #1;
    for (int i = 0; i < count; i++) begin
      bit hs;
      int w;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        bus.in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(s[i]);
      hs = 0;
      w  = 0;
      while (!hs && w < 300) begin
        @(negedge clk);
        hs = bus.in_ready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!hs) check("accept_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int c = 0;
    while (frames_done < target && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("frame_timeout", int'(frames_done >= target), 1);
    #1;
  endtask

  task automatic cmp_table(input string tag, input vec8_t t);
    check({tag, "_len"}, beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++) check(tag, beat_log[i], t[i]);
  endtask

  vec8_t seq_t, dc_t, basic_t, dcres_t, rnd_t;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    seq_t = '{1, 2, 3, 4, 5, 6, 7, 8};
    dc_t  = '{10, 10, 10, 10, 10, 10, 10, 10};
`ifdef HADAMARD8_CTRL_SCALE_EN
    basic_t = '{4, -1, -1, 0, -2, 0, 0, 0};
    dcres_t = '{10, 0, 0, 0, 0, 0, 0, 0};
`else
    basic_t = '{36, -4, -8, 0, -16, 0, 0, 0};
    dcres_t = '{80, 0, 0, 0, 0, 0, 0, 0};
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", int'(bus.in_ready), 1);
    check("busy_idle", int'(busy), 0);

    // Basic frame
    beat_log.delete();
    send(seq_t, 8, 0);
    wait_frames(1);
    cmp_table("basic", basic_t);

    // DC input
    beat_log.delete();
    send(dc_t, 8, 0);
    wait_frames(2);
    cmp_table("dc", dcres_t);

    // Backpressure on both sides
    orm = 1;
    or_phase = 0;
    beat_log.delete();
    send(seq_t, 8, 1);
    wait_frames(3);
    cmp_table("bp", basic_t);
    orm = 0;

    // Reset after five samples, then a clean frame
    for (int i = 0; i < 8; i++) rnd_t[i] = int'($signed(8'($urandom)));
    send(rnd_t, 5, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    beat_log.delete();
    send(seq_t, 8, 0);
    wait_frames(4);
    cmp_table("rst_load", basic_t);

    // Reset during drain after three beats
    beat_log.delete();
    send(seq_t, 8, 0);
    begin
      int c = 0;
      while (beat_log.size() < 3 && c < 200) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("drain_rst_beats", beat_log.size(), 3);
    check("drain_rst_frames", frames_done, 4);

    // Randomised frames
    orm = 2;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 8; i++) rnd_t[i] = int'($signed(8'($urandom)));
      send(rnd_t, 8, 1'($urandom_range(0, 1)));
    end
    wait_frames(24);
    orm = 0;
    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
